icap_reboot_ctrl: RTL and testbench



---
 rtl/icap_reboot_ctrl.sv | 152 +++++++++++++++
 tb/tb_icap_reboot_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/icap_reboot_ctrl.sv
// Warm-reboot controller: on a reboot pulse, drives ICAPE2 through the 8-word IPROG
// sequence with the latched WBSTAR address. Define ICAP_BITSWAP_EN for per-byte bit reversal.
`timescale 1ns/1ps
module icap_reboot_ctrl #(
  parameter int unsigned ARM_DELAY  = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        reboot,
  input  logic [31:0] rebootAddress,
  output logic        icapCsN,
  output logic        icapRdWrN,
  output logic [31:0] icapData,
  output logic        busy,
  output logic        done,
  output logic [2:0]  wordIndex
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_SETUP, S_WRITE, S_GAP, S_FINISH, S_DONE
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [15:0] delay_cnt_q;
  logic [7:0]  gap_cnt_q;
  logic [2:0]  word_ptr_q;   // next word to present; wordIndex tracks the last one presented
  logic        cs_n_q;
  logic        rdwr_n_q;
  logic [31:0] data_q;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  word_idx_q;
  logic [31:0] raw_word;
  logic [31:0] word_d;

  function automatic logic [31:0] cmd_word(input logic [2:0] idx, input logic [31:0] wbstar);
    logic [31:0] w;
    case (idx)
      3'd0:    w = 32'hFFFF_FFFF;
      3'd1:    w = 32'hAA99_5566;
      3'd2:    w = 32'h2000_0000;
      3'd3:    w = 32'h3002_0001;
      3'd4:    w = wbstar;
      3'd5:    w = 32'h3000_8001;
      3'd6:    w = 32'h0000_000F;
      default: w = 32'h2000_0000;
    endcase
    return w;
  endfunction

  assign raw_word = cmd_word(word_ptr_q, addr_q);

`ifdef ICAP_BITSWAP_EN
  function automatic logic [31:0] byte_bitswap(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b + i] = w[8*b + 7 - i];
      end
    end
    return r;
  endfunction

  assign word_d = byte_bitswap(raw_word);
`else
  assign word_d = raw_word;
`endif

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      delay_cnt_q <= '0;
      gap_cnt_q   <= '0;
      word_ptr_q  <= '0;
      cs_n_q      <= 1'b1;
      rdwr_n_q    <= 1'b1;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_idx_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (reboot) begin
            addr_q      <= rebootAddress;
            busy_q      <= 1'b1;
            delay_cnt_q <= 16'(ARM_DELAY);
            state_q     <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (delay_cnt_q == '0) begin
            state_q <= S_SETUP;
          end else begin
            delay_cnt_q <= delay_cnt_q - 16'd1;
          end
        end
        S_SETUP: begin
          // RDWRB settles a full cycle before CSIB first goes low.
          rdwr_n_q   <= 1'b0;
          word_ptr_q <= '0;
          word_idx_q <= '0;
          state_q    <= S_WRITE;
        end
        S_WRITE: begin
          cs_n_q     <= 1'b0;
          data_q     <= word_d;
          word_idx_q <= word_ptr_q;
          if (word_ptr_q == 3'd7) begin
            state_q <= S_FINISH;
          end else if (GAP_CYCLES == 0) begin
            word_ptr_q <= word_ptr_q + 3'd1;
          end else begin
            gap_cnt_q <= 8'(GAP_CYCLES - 1);
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          cs_n_q <= 1'b1;
          if (gap_cnt_q == '0) begin
            word_ptr_q <= word_ptr_q + 3'd1;
            state_q    <= S_WRITE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        S_FINISH: begin
          cs_n_q  <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          cs_n_q   <= 1'b1;
          rdwr_n_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign icapCsN   = cs_n_q;
  assign icapRdWrN = rdwr_n_q;
  assign icapData  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wordIndex = word_idx_q;

endmodule

// File: tb/tb_icap_reboot_ctrl.sv
// Self-checking bench for icap_reboot_ctrl: one instance without gaps, one with GAP_CYCLES=3.
// Honours ICAP_BITSWAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_icap_reboot_ctrl;

  localparam int ARM_A = 16;
  localparam int GAP_A = 0;
  localparam int ARM_B = 5;
  localparam int GAP_B = 3;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        reboot_a = 1'b0, reboot_b = 1'b0;
  logic [31:0] addr_a = '0, addr_b = '0;
  logic        cs_a, rw_a, busy_a, done_a, cs_b, rw_b, busy_b, done_b;
  logic [31:0] data_a, data_b;
  logic [2:0]  wi_a, wi_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  icap_reboot_ctrl #(.ARM_DELAY(ARM_A), .GAP_CYCLES(GAP_A)) dut_a (
    .clk(clk), .nReset(n_reset), .reboot(reboot_a), .rebootAddress(addr_a),
    .icapCsN(cs_a), .icapRdWrN(rw_a), .icapData(data_a),
    .busy(busy_a), .done(done_a), .wordIndex(wi_a));

  icap_reboot_ctrl #(.ARM_DELAY(ARM_B), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .nReset(n_reset), .reboot(reboot_b), .rebootAddress(addr_b),
    .icapCsN(cs_b), .icapRdWrN(rw_b), .icapData(data_b),
    .busy(busy_b), .done(done_b), .wordIndex(wi_b));

  // Packed observation: {cs, rdwr, data[31:0], busy, done, wordIndex[2:0]}
  function automatic logic [38:0] pack(logic cs, logic rw, logic [31:0] d, logic b, logic dn, logic [2:0] wi);
    return {cs, rw, d, b, dn, wi};
  endfunction

  localparam logic [38:0] RESET_OUTS = {1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 3'd0};

  function automatic logic [38:0] outs(input int sel);
    if (sel == 0) return pack(cs_a, rw_a, data_a, busy_a, done_a, wi_a);
    return pack(cs_b, rw_b, data_b, busy_b, done_b, wi_b);
  endfunction

  function automatic logic [31:0] ref_word(input int idx, input logic [31:0] addr);
    logic [31:0] tbl [8];
    logic [31:0] w;
    logic [31:0] r;
    tbl = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
            32'h0, 32'h30008001, 32'h0000000F, 32'h20000000};
    tbl[4] = addr;
    w = tbl[idx];
    r = w;
`ifdef ICAP_BITSWAP_EN
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[8*b + i] = w[8*b + 7 - i];
`endif
    return r;
  endfunction

  // Expected outputs sampled after edge k+t, where edge k accepted the reboot.
  function automatic logic [38:0] model(input int t, input int arm, input int gap, input logic [31:0] addr);
    int first, period, last, idx;
    logic cs, rw, dn;
    logic [31:0] d;
    logic [2:0] wi;
    first = arm + 3;
    period = gap + 1;
    last = first + 7 * period;
    cs = 1'b1; rw = 1'b1; dn = 1'b0; d = '0; wi = '0;
    if (t >= arm + 2 && t <= last + 1) rw = 1'b0;
    if (t >= first) begin
      idx = (t - first) / period;
      if (idx > 7) idx = 7;
      wi = 3'(idx);
      d = ref_word(idx, addr);
      if (t <= last && (t - first) % period == 0) cs = 1'b0;
    end
    if (t > last) dn = 1'b1;
    return pack(cs, rw, d, 1'b1, dn, wi);
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got cs/rw/data/busy/done/wi=%b/%b/%h/%b/%b/%0d want %b/%b/%h/%b/%b/%0d",
               name, act[38], act[37], act[36:5], act[4], act[3], act[2:0],
               exp[38], exp[37], exp[36:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rb, input logic [31:0] addr);
    if (sel == 0) begin reboot_a = rb; addr_a = addr; end
    else          begin reboot_b = rb; addr_b = addr; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    reboot_a = 1'b0; reboot_b = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
  endtask

  // Full sequence with stray pulses in DELAY and DONE, and the address bus changing after accept.
  task automatic run_seq(input int sel, input logic [31:0] addr, input int hold, input bit noise);
    int arm, gap, last, lows;
    logic rb;
    logic [38:0] o;
    arm = (sel == 0) ? ARM_A : ARM_B;
    gap = (sel == 0) ? GAP_A : GAP_B;
    last = arm + 3 + 7 * (gap + 1);
    lows = 0;
    @(negedge clk);
    drive(sel, 1'b1, addr);
    for (int t = 0; t <= last + arm + 6; t++) begin
      @(negedge clk);
      rb = (t + 1 < hold);
      if (t == arm / 2 || t == last + 2) rb = 1'b1;
      if (noise && $urandom_range(0, 3) == 0) rb = 1'b1;
      drive(sel, rb, noise ? 32'($urandom) : 32'h12345678);
      o = outs(sel);
      check($sformatf("seq%0d t=%0d", sel, t), o, model(t, arm, gap, addr));
      if (o[38] == 1'b0) lows++;
    end
    drive(sel, 1'b0, '0);
    check_int($sformatf("seq%0d cs pulses", sel), lows, 8);
  endtask

  typedef struct {
    int          t;
    logic [38:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [31:0] w [8];
    int n_hit;

`ifdef ICAP_BITSWAP_EN
    w = '{32'hFFFFFFFF, 32'h5599AA66, 32'h04000000, 32'h0C400080,
          32'h00020000, 32'h0C000180, 32'h000000F0, 32'h04000000};
`else
    w = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
          32'h00400000, 32'h30008001, 32'h0000000F, 32'h20000000};
`endif
    vecs.push_back('{0,  pack(1, 1, 32'h0, 1, 0, 3'd0)});
    vecs.push_back('{17, pack(1, 1, 32'h0, 1, 0, 3'd0)});
    vecs.push_back('{18, pack(1, 0, 32'h0, 1, 0, 3'd0)});
    for (int i = 0; i < 8; i++) vecs.push_back('{19 + i, pack(0, 0, w[i], 1, 0, 3'(i))});
    vecs.push_back('{27, pack(1, 0, w[7], 1, 1, 3'd7)});
    vecs.push_back('{28, pack(1, 1, w[7], 1, 1, 3'd7)});
    vecs.push_back('{40, pack(1, 1, w[7], 1, 1, 3'd7)});

    // Reset, then 100 idle cycles on both instances.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check($sformatf("idle a c=%0d", c), outs(0), RESET_OUTS);
      check($sformatf("idle b c=%0d", c), outs(1), RESET_OUTS);
    end

    // Directed vectors: address 00400000, single-cycle pulse.
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 32'h00400000);
    n_hit = 0;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      drive(0, 1'b0, 32'h00400000);
      foreach (vecs[i]) begin
        if (vecs[i].t == t) begin
          check($sformatf("vec t=%0d", t), outs(0), vecs[i].exp);
          n_hit++;
        end
      end
    end
    check_int("vec entries applied", n_hit, vecs.size());

    // Stray pulses in DELAY/DONE with the address bus moved to 12345678.
    do_reset();
    run_seq(0, 32'h00400000, 1, 1'b0);
    do_reset();
    run_seq(1, 32'h00400000, 1, 1'b0);

    // Randomized runs: random address, held pulse, random extra pulses.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      run_seq(r % 2, 32'($urandom), $urandom_range(1, 3), 1'b1);
    end

    // Reset mid-sequence while word 3 is on the bus, then a clean restart.
    do_reset();
    @(negedge clk);
    drive(0, 1'b1, 32'hCAFE0000);
    for (int t = 0; t <= ARM_A + 6; t++) begin
      @(negedge clk);
      drive(0, 1'b0, 32'hCAFE0000);
    end
    check("pre-abort word3", outs(0), model(ARM_A + 6, ARM_A, GAP_A, 32'hCAFE0000));
    n_reset = 1'b0;
    #1;
    check("abort async", outs(0), RESET_OUTS);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    check("after abort idle", outs(0), RESET_OUTS);
    run_seq(0, 32'h00ABC000, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
